time_day_counter: RTL and testbench
===================================

TIME_DAY_COUNTER -- requirements
Module: time_day_counter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz; used only when TICK_PRESCALE_EN is defined.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-clk-wide 1 Hz pulse; ignored when TICK_PRESCALE_EN is defined.
REQ-005 hold  input  1  while high, time does not advance; ticks are dropped.
REQ-006 load  input  1  one-clk pulse requesting a time/day set.
REQ-007 set_time  input  13  BCD HH:MM for load, same encoding as CT.
REQ-008 set_day  input  3  day for load, 0..6.
REQ-009 CT  output  13  current time, BCD: [12:11] hour tens, [10:7] hour units, [6:4] minute tens, [3:0] minute units.
REQ-010 CD  output  3  current day of week, 0..6.
REQ-011 min_stb  output  1  one-clk pulse in the cycle CT first shows a new minute value.
REQ-012 load_err  output  1  one-clk pulse when a load is rejected.

Function
REQ-013 Internal seconds counter, binary 0..59, not output.
REQ-014 Each accepted tick increments seconds; CT, CD and seconds are registered and show the new value the cycle after the tick is sampled.
REQ-015 Seconds 59 plus tick -> seconds 0 and minute increments in the same update.
REQ-016 Minute units 9 -> 0 with carry into minute tens; minute tens 5 -> 0 with carry into hour.
REQ-017 Hour 23 -> 00 with carry into CD; CD 6 -> 0 (wrap).
REQ-018 min_stb is asserted exactly in the cycle CT changes due to a rollover or an accepted load; it is never asserted otherwise.
REQ-019 Valid load: hour <= 23, minute tens <= 5, minute units <= 9, set_day <= 6; any other value is invalid.
REQ-020 Valid load: next cycle CT=set_time, CD=set_day, seconds=0, min_stb=1.
REQ-021 Invalid load: CT, CD and seconds unchanged; load_err=1 for one cycle; any tick in that cycle is still applied.
REQ-022 load and tick in the same cycle with a valid load: the load wins and the tick is discarded.
REQ-023 load is accepted regardless of hold.
REQ-024 hold high with a tick: the tick is discarded, not queued.
REQ-025 CT and CD never leave the legal ranges defined in REQ-019.

Reset
REQ-026 rst_n low asynchronously forces CT=0 (00:00), CD=0, seconds=0, min_stb=0, load_err=0, and clears the prescaler.
REQ-027 Reset asserted mid-rollover or mid-load discards the pending update; after deassertion, counting resumes from 00:00 with day 0 on the next accepted tick.

Configuration
REQ-028 Macro TICK_PRESCALE_EN:
- Defined: an internal counter 0..CLK_HZ-1 generates the 1 Hz tick; the tick port is ignored; hold also freezes the prescaler.
- Undefined: the tick input is used directly and no prescaler logic exists.

Structure
REQ-029 Shared package contents: BCD field widths and bit positions of CT, DAY_MAX=6, HOUR_MAX=23, SEC_MAX=59, and a time-validity function reused by the alarm-register write path.
REQ-030 One sub-module, bcd_digit_counter (programmable max, carry in/out), is instantiated per minute/hour digit; the hour-tens/units 23 wrap is handled in this block.

Verification
REQ-031 Reset, then 60 ticks -> CT=13'b00_0000_000_0001 (00:01); min_stb pulses once.
REQ-032 Load 23:59, day 6; then 60 ticks -> CT=0, CD=0, exactly one min_stb.
REQ-033 Load with minute tens=6, or hour=24, or set_day=7 -> load_err pulse; CT and CD unchanged.
REQ-034 load and tick in the same cycle with a valid 12:30 -> CT=12:30 and seconds=0; the tick is lost.
REQ-035 hold high across 100 ticks -> CT constant, no min_stb; counting resumes on the first tick after hold drops.
REQ-036 rst_n pulsed low between clock edges at 09:59:59 -> outputs go to zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/time_day_counter_pkg.sv
// Shared definitions for the time/day counter: BCD field layout of CT, range limits
// and the time-validity check also used by the alarm-register write path.
package time_day_counter_pkg;

  localparam int CT_W   = 13;
  localparam int HT_W   = 2;
  localparam int HU_W   = 4;
  localparam int MT_W   = 3;
  localparam int MU_W   = 4;
  localparam int HT_LSB = 11;
  localparam int HU_LSB = 7;
  localparam int MT_LSB = 4;
  localparam int MU_LSB = 0;
  localparam int DAY_W  = 3;
  localparam int SEC_W  = 6;

  localparam int DAY_MAX  = 6;
  localparam int HOUR_MAX = 23;
  localparam int SEC_MAX  = 59;

  typedef struct packed {
    logic [HT_W-1:0] ht;
    logic [HU_W-1:0] hu;
    logic [MT_W-1:0] mt;
    logic [MU_W-1:0] mu;
  } bcd_time_t;

  // True when every BCD digit is legal and the hour does not exceed 23.
  function automatic logic time_valid(input bcd_time_t t);
    int hour;
    hour = int'(t.ht) * 10 + int'(t.hu);
    return (t.hu <= 4'd9) && (hour <= HOUR_MAX) && (t.mt <= 3'd5) && (t.mu <= 4'd9);
  endfunction

endpackage

// File: rtl/time_day_counter_bcd_digit.sv
// bcd_digit_counter: one BCD digit with programmable maximum, parallel load and
// carry in/out; carry_o is high when an increment wraps the digit back to zero.
module bcd_digit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] max_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o,
  output logic         carry_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (inc_i) begin
      q_d = (q_q == max_i) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = inc_i && !load_i && (q_q == max_i);

endmodule

// File: rtl/time_day_counter.sv
// Time-of-day (BCD HH:MM) and day-of-week counter advanced by a 1 Hz tick.
// Optional macro TICK_PRESCALE_EN derives the tick internally from CLK_HZ.
module time_day_counter
  import time_day_counter_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             hold,
  input  logic             load,
  input  logic [CT_W-1:0]  set_time,
  input  logic [DAY_W-1:0] set_day,
  output logic [CT_W-1:0]  CT,
  output logic [DAY_W-1:0] CD,
  output logic             min_stb,
  output logic             load_err
);

  if (CLK_HZ < 1) begin : gBadClkHz
    $error("CLK_HZ must be at least 1");
  end

  bcd_time_t setT;
  logic      tickAcc;
  logic      loadOk;
  logic      advance;
  logic      secWrap;
  logic      muCarry, mtCarry, huCarry, htCarry;
  logic [HU_W-1:0] huMax;

  logic [SEC_W-1:0] sec_q, sec_d;
  logic [DAY_W-1:0] day_q, day_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;
  logic [HT_W-1:0]  ht_q;
  logic [HU_W-1:0]  hu_q;
  logic [MT_W-1:0]  mt_q;
  logic [MU_W-1:0]  mu_q;

  assign setT = set_time;

`ifdef TICK_PRESCALE_EN
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          preWrap;

  assign preWrap = (pre_q == PW'(CLK_HZ - 1));

  always_comb begin
    pre_d = pre_q;
    if (!hold) begin
      pre_d = preWrap ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tickAcc = preWrap && !hold;
`else
  assign tickAcc = tick && !hold;
`endif

  // A valid load overrides any tick in the same cycle; an invalid one lets it through.
  assign loadOk  = load && time_valid(setT) && (set_day <= DAY_W'(DAY_MAX));
  assign advance = tickAcc && !loadOk;
  assign secWrap = advance && (sec_q == SEC_W'(SEC_MAX));
  assign huMax   = (ht_q == 2'd2) ? 4'd3 : 4'd9;

  bcd_digit_counter #(.W(MU_W)) uMinUnits (
    .clk(clk), .rst_n(rst_n), .max_i(4'd9), .load_i(loadOk), .load_val_i(setT.mu),
    .inc_i(secWrap), .q_o(mu_q), .carry_o(muCarry)
  );

  bcd_digit_counter #(.W(MT_W)) uMinTens (
    .clk(clk), .rst_n(rst_n), .max_i(3'd5), .load_i(loadOk), .load_val_i(setT.mt),
    .inc_i(muCarry), .q_o(mt_q), .carry_o(mtCarry)
  );

  bcd_digit_counter #(.W(HU_W)) uHourUnits (
    .clk(clk), .rst_n(rst_n), .max_i(huMax), .load_i(loadOk), .load_val_i(setT.hu),
    .inc_i(mtCarry), .q_o(hu_q), .carry_o(huCarry)
  );

  bcd_digit_counter #(.W(HT_W)) uHourTens (
    .clk(clk), .rst_n(rst_n), .max_i(2'd2), .load_i(loadOk), .load_val_i(setT.ht),
    .inc_i(huCarry), .q_o(ht_q), .carry_o(htCarry)
  );

  always_comb begin
    sec_d = sec_q;
    day_d = day_q;
    stb_d = loadOk || secWrap;
    err_d = load && !loadOk;
    if (loadOk) begin
      sec_d = '0;
      day_d = set_day;
    end else if (advance) begin
      sec_d = secWrap ? '0 : sec_q + 1'b1;
      if (htCarry) begin
        day_d = (day_q == DAY_W'(DAY_MAX)) ? '0 : day_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= '0;
      day_q <= '0;
      stb_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sec_q <= sec_d;
      day_q <= day_d;
      stb_q <= stb_d;
      err_q <= err_d;
    end
  end

  assign CT       = {ht_q, hu_q, mt_q, mu_q};
  assign CD       = day_q;
  assign min_stb  = stb_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_time_day_counter.sv
// Scoreboard bench for time_day_counter: stimulus pushes per-cycle expectations
// from a minutes-of-day reference model, a negedge monitor pops and compares.
module tb_time_day_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, hold, load;
  logic [12:0] set_time;
  logic [2:0]  set_day;
  logic [12:0] CT;
  logic [2:0]  CD;
  logic        min_stb, load_err;

  typedef struct {
    logic [12:0] ct;
    logic [2:0]  cd;
    logic        stb;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   mSec, mMin, mDay;

  time_day_counter #(.CLK_HZ(50_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .hold(hold), .load(load),
    .set_time(set_time), .set_day(set_day),
    .CT(CT), .CD(CD), .min_stb(min_stb), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] bcd(input int ht, input int hu, input int mt, input int mu);
    return {2'(ht), 4'(hu), 3'(mt), 4'(mu)};
  endfunction

  function automatic logic [12:0] toBcd(input int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return bcd(h / 10, h % 10, mm / 10, mm % 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model and queue the expectation.
  task automatic applyStimulus(input logic t, input logic h, input logic l,
                               input logic [12:0] st, input logic [2:0] sd);
    int ht, hu, mt, mu;
    bit ok;
    exp_t e;
    @(negedge clk);
    tick = t; hold = h; load = l; set_time = st; set_day = sd;
    @(posedge clk);
    ht = int'(st[12:11]); hu = int'(st[10:7]); mt = int'(st[6:4]); mu = int'(st[3:0]);
    ok = (hu <= 9) && (ht * 10 + hu <= 23) && (mt <= 5) && (mu <= 9) && (sd <= 6);
    e.stb = 1'b0;
    e.err = l && !ok;
    if (l && ok) begin
      mMin  = (ht * 10 + hu) * 60 + mt * 10 + mu;
      mDay  = int'(sd);
      mSec  = 0;
      e.stb = 1'b1;
    end else if (t && !h) begin
      mSec++;
      if (mSec == 60) begin
        mSec  = 0;
        e.stb = 1'b1;
        mMin++;
        if (mMin == 1440) begin
          mMin = 0;
          mDay = (mDay + 1) % 7;
        end
      end
    end
    e.ct = toBcd(mMin);
    e.cd = 3'(mDay);
    sb.push_back(e);
  endtask

  task automatic ticks(input int n, input logic h);
    repeat (n) applyStimulus(1'b1, h, 1'b0, 13'd0, 3'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 13'd0, 3'd0);
  endtask

  task automatic checkNow(input string name, input logic [12:0] ct, input logic [2:0] cd);
    #1;
    checkOutput({name, " CT"}, CT, ct);
    checkOutput({name, " CD"}, CD, cd);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("CT", CT, e.ct);
        checkOutput("CD", CD, e.cd);
        checkOutput("min_stb", min_stb, e.stb);
        checkOutput("load_err", load_err, e.err);
      end
    end
  end

  initial begin : stimulus
    int waitCnt;
    rst_n = 1'b0; tick = 1'b0; hold = 1'b0; load = 1'b0; set_time = '0; set_day = '0;
    mSec = 0; mMin = 0; mDay = 0;
    #12;
    checkOutput("reset CT", CT, 13'd0);
    checkOutput("reset CD", CD, 3'd0);
    checkOutput("reset min_stb", min_stb, 1'b0);
    checkOutput("reset load_err", load_err, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    ticks(60, 1'b0);
    checkNow("first minute", bcd(0, 0, 0, 1), 3'd0);

    applyStimulus(1'b0, 1'b0, 1'b1, bcd(2, 3, 5, 9), 3'd6);
    checkNow("load 23:59", bcd(2, 3, 5, 9), 3'd6);
    ticks(59, 1'b0);
    checkNow("23:59:59", bcd(2, 3, 5, 9), 3'd6);
    ticks(1, 1'b0);
    checkNow("week wrap", 13'd0, 3'd0);

    applyStimulus(1'b0, 1'b0, 1'b1, bcd(1, 0, 6, 0), 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, bcd(2, 4, 0, 0), 3'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, bcd(0, 5, 0, 0), 3'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, bcd(0, 1, 0, 10), 3'd2);
    checkNow("invalid loads", 13'd0, 3'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, bcd(1, 2, 3, 0), 3'd2);
    ticks(59, 1'b0);
    checkNow("load beats tick", bcd(1, 2, 3, 0), 3'd2);
    ticks(1, 1'b0);
    checkNow("after load minute", bcd(1, 2, 3, 1), 3'd2);

    ticks(100, 1'b1);
    checkNow("held", bcd(1, 2, 3, 1), 3'd2);
    ticks(60, 1'b0);
    checkNow("resume after hold", bcd(1, 2, 3, 2), 3'd2);

    applyStimulus(1'b0, 1'b1, 1'b1, bcd(0, 9, 5, 9), 3'd5);
    ticks(59, 1'b0);
    checkNow("09:59:59", bcd(0, 9, 5, 9), 3'd5);

    @(negedge clk);
    tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset CT", CT, 13'd0);
    checkOutput("async reset CD", CD, 3'd0);
    checkOutput("async reset min_stb", min_stb, 1'b0);
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    #2 rst_n = 1'b1;
    mSec = 0; mMin = 0; mDay = 0;
    #1;
    checkOutput("reset held CT", CT, 13'd0);
    ticks(60, 1'b0);
    checkNow("after reset minute", bcd(0, 0, 0, 1), 3'd0);
    idle(2);

    waitCnt = 0;
    while (sb.size() > 0 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    #1;
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
